// File: rtl/xps2_rx_pkg.sv
// Shared definitions for the PS/2 receiver: register map, status bits, FSM states.
package xps2_rx_pkg;

  // Register offsets
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;
  localparam logic [1:0] RegRsvd   = 2'd3;

  // STATUS bit positions
  localparam int unsigned StatEmpty  = 0;
  localparam int unsigned StatFull   = 1;
  localparam int unsigned StatErr    = 2;
  localparam int unsigned StatOvf    = 3;
  localparam int unsigned StatCntLsb = 8;

  // CTRL bit positions
  localparam int unsigned CtrlFlush = 0;
  localparam int unsigned CtrlClear = 1;

  // DATA register valid flag position
  localparam int unsigned DataValid = 15;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // A frame is good when the stop bit is high and data+parity hold an odd number of ones.
  function automatic logic frame_ok(input logic [7:0] byte_v, input logic par, input logic stop);
    return stop & (^{par, byte_v});
  endfunction

endpackage

// File: rtl/xfifo_sync.sv
// Parameterized synchronous FIFO with push, pop, flush and occupancy count.
module xfifo_sync #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(Depth));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state: a pop frees a slot so a push on a full FIFO still lands; flush beats both.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/xps2_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 pins, deframes 11-bit
// device-to-host frames, buffers good bytes in a FIFO and exposes DATA/STATUS/CTRL.
module xps2_rx #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  import xps2_rx_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW = $clog2(FILT_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FiltLast = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] ToMax    = TW'(TIMEOUT);

  // Synchronizers and clock filter
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_stb;

  // Deframer
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push, err_set;

  // Status flags and bus decode
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          pop, flush, clr, ovf_set;

  // FIFO
  logic [7:0]    fifo_rdata;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;

  // Only the low CTRL bits carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^data_in[DATA_W-1:2];

  // Two-stage synchronizers; filtered clock flips only after FILT_LEN differing samples.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FiltLast) begin
        filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
    fall_stb = filt_q & ~filt_d;
  end

  // Frame FSM and inactivity timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push      = 1'b0;
    err_set   = 1'b0;
    to_cnt_d  = to_cnt_q;
    if (fall_stb) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != ToMax) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    case (state_q)
      StIdle: begin
        if (fall_stb && !dat_s2_q) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall_stb) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (fall_stb) begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall_stb) begin
          state_d = StIdle;
          if (frame_ok(shift_q, par_q, dat_s2_q)) begin
            push = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // The counter reloads on a strobe, so this only fires after real silence.
    if (!fall_stb && state_q != StIdle && to_cnt_q == ToMax) begin
      state_d = StIdle;
      err_set = 1'b1;
    end
  end

  // Bus decode and sticky ERR/OVF; a set in the same cycle as a clear wins.
  always_comb begin
    pop     = sel & ~we & (addr == RegData) & ~fifo_empty;
    flush   = sel & we & (addr == RegCtrl) & data_in[CtrlFlush];
    clr     = sel & we & (addr == RegCtrl) & data_in[CtrlClear];
    ovf_set = push & fifo_full & ~pop & ~flush;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (clr) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    data_out = '0;
    case (addr)
      RegData: begin
        if (!fifo_empty) begin
          data_out[DataValid] = 1'b1;
          data_out[7:0]       = fifo_rdata;
        end
      end
      RegStatus: begin
        data_out[StatEmpty]          = fifo_empty;
        data_out[StatFull]           = fifo_full;
        data_out[StatErr]            = err_q;
        data_out[StatOvf]            = ovf_q;
        data_out[StatCntLsb +: CW]   = fifo_count;
      end
      RegCtrl, RegRsvd: data_out = '0;
      default: data_out = '0;
    endcase
  end

  xfifo_sync #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .wdata_i(shift_q),
    .pop_i  (pop),
    .flush_i(flush),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .count_o(fifo_count)
  );

  // State registers with synchronous reset; idle pin level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_xps2_rx.sv
// Directed bench for xps2_rx: drives PS/2 frames on the pins and checks the register view.
module tb_xps2_rx;
  import xps2_rx_pkg::*;

  localparam int unsigned Tmo = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_err    = 0;

  xps2_rx #(
    .DATA_W    (32),
    .FIFO_DEPTH(8),
    .FILT_LEN  (4),
    .TIMEOUT   (Tmo)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    v = data_out;
    @(posedge clk);
    #1;
    sel = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel     = 1'b1;
    we      = 1'b1;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    sel     = 1'b0;
    we      = 1'b0;
    data_in = '0;
  endtask

  // Frame bits, index 0 first on the wire: start, d0..d7, parity, stop.
  function automatic logic [10:0] mk(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    return {1'b1, p, b, 1'b0};
  endfunction

  // Sends nbits of a frame; optional 3-cycle clock glitch after bit glitch_at; optional
  // DATA read landing on the same edge the stop strobe is consumed.
  task automatic send(input logic [10:0] f, input int nbits, input int glitch_at,
                      input bit pop_stop, input logic [31:0] pop_exp);
    logic [31:0] v;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(20);
      ps2_clk = 1'b0;
      if (pop_stop && i == 10) begin
        wait_cyc(5);
        rd(RegData, v);
        chk("pop_on_stop_data", v, pop_exp);
        wait_cyc(14);
      end else begin
        wait_cyc(20);
      end
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  initial begin
    logic [31:0] v;

    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);

    // Reset state
    rd(RegStatus, v); chk("reset_status", v, 32'h0000_0001);
    rd(RegData, v);   chk("reset_data_empty", v, 32'h0000_0000);

    // Good frame 0x1C
    send(mk(8'h1C, 1'b0), 11, -1, 1'b0, 32'h0);
    rd(RegStatus, v); chk("1c_status", v, 32'h0000_0100);
    rd(RegData, v);   chk("1c_data", v, 32'h0000_801C);
    rd(RegStatus, v); chk("1c_status_after_pop", v, 32'h0000_0001);

    // Bad parity frame 0x5A
    send(mk(8'h5A, 1'b1), 11, -1, 1'b0, 32'h0);
    rd(RegStatus, v); chk("parity_err_status", v, 32'h0000_0005);
    wr(RegCtrl, 32'h2);
    rd(RegStatus, v); chk("err_cleared", v, 32'h0000_0001);

    // Timeout after start + 4 data bits, then a good frame
    send(mk(8'hA5, 1'b0), 5, -1, 1'b0, 32'h0);
    wait_cyc(Tmo + 50);
    rd(RegStatus, v); chk("timeout_err", v, 32'h0000_0005);
    wr(RegCtrl, 32'h2);
    rd(RegStatus, v); chk("timeout_cleared", v, 32'h0000_0001);
    send(mk(8'hF0, 1'b0), 11, -1, 1'b0, 32'h0);
    rd(RegStatus, v); chk("f0_status", v, 32'h0000_0100);
    rd(RegData, v);   chk("f0_data", v, 32'h0000_80F0);

    // Overflow: 9 frames into 8 entries
    for (int i = 1; i <= 9; i++) send(mk(8'(i), 1'b0), 11, -1, 1'b0, 32'h0);
    rd(RegStatus, v); chk("ovf_status", v, 32'h0000_080A);
    for (int i = 1; i <= 8; i++) begin
      rd(RegData, v); chk("ovf_order", v, 32'h0000_8000 | 32'(i));
    end
    rd(RegStatus, v); chk("ovf_drained", v, 32'h0000_0009);
    wr(RegCtrl, 32'h2);
    rd(RegStatus, v); chk("ovf_cleared", v, 32'h0000_0001);

    // Flush
    send(mk(8'h33, 1'b0), 11, -1, 1'b0, 32'h0);
    send(mk(8'h44, 1'b0), 11, -1, 1'b0, 32'h0);
    rd(RegStatus, v); chk("pre_flush", v, 32'h0000_0200);
    wr(RegCtrl, 32'h1);
    rd(RegStatus, v); chk("post_flush", v, 32'h0000_0001);

    // Pop coinciding with the stop strobe on a full FIFO
    for (int i = 0; i < 8; i++) send(mk(8'h11 + 8'(i), 1'b0), 11, -1, 1'b0, 32'h0);
    rd(RegStatus, v); chk("full_before", v, 32'h0000_0802);
    send(mk(8'h19, 1'b0), 11, -1, 1'b1, 32'h0000_8011);
    rd(RegStatus, v); chk("full_after_pop_push", v, 32'h0000_0802);
    for (int i = 0; i < 8; i++) begin
      rd(RegData, v); chk("pop_push_order", v, 32'h0000_8012 + 32'(i));
    end
    rd(RegStatus, v); chk("pop_push_drained", v, 32'h0000_0001);

    // Short glitch on ps2_clk mid-frame is ignored
    send(mk(8'h3C, 1'b0), 11, 3, 1'b0, 32'h0);
    rd(RegStatus, v); chk("glitch_status", v, 32'h0000_0100);
    rd(RegData, v);   chk("glitch_data", v, 32'h0000_803C);

    // Reset mid-frame with a byte buffered
    send(mk(8'h2A, 1'b0), 11, -1, 1'b0, 32'h0);
    rd(RegStatus, v); chk("pre_reset_status", v, 32'h0000_0100);
    send(mk(8'h77, 1'b0), 5, -1, 1'b0, 32'h0);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);
    rd(RegStatus, v); chk("mid_reset_status", v, 32'h0000_0001);
    send(mk(8'h66, 1'b0), 11, -1, 1'b0, 32'h0);
    rd(RegData, v);   chk("post_reset_data", v, 32'h0000_8066);
    rd(RegStatus, v); chk("post_reset_status", v, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/xps2_rx.md
# xps2_rx

PS/2 keyboard receiver peripheral on the calculator controller's data bus. It samples the asynchronous PS/2 clock and data lines, deframes 11-bit device-to-host frames and checks parity. Received scan-code bytes go into a small FIFO. The controller reads that FIFO and a status register through its memory-mapped read/write interface.

## Interface
- DATA_W, 32, data bus width; must be ≥ 16
- FIFO_DEPTH, 8, scan-code FIFO entries; power of two, ≥ 2
- FILT_LEN, 4, consecutive equal samples needed to accept a new ps2_clk level
- TIMEOUT, 20000, clk cycles without a PS/2 falling edge before a partial frame is abandoned

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ps2_clk  in  1  PS/2 clock pin, asynchronous
- ps2_data  in  1  PS/2 data pin, asynchronous
- sel  in  1  peripheral selected by the controller's data bus
- we  in  1  write strobe, qualified by sel
- addr  in  2  register offset
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  read data, combinational from addr and state

## Operation
- ps2_clk and ps2_data each pass through a 2-FF synchronizer. Filtered ps2_clk changes level only after FILT_LEN equal synchronized samples.
- A falling edge of the filtered ps2_clk is a one-cycle strobe. ps2_data is sampled on that strobe.
- FSM states and transitions:
  - IDLE: on a strobe with data=0 (start bit), go to DATA. A strobe with data=1 is ignored.
  - DATA: shift in 8 bits, LSB first, using bit counter 0..7. After bit 7, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on the stop strobe, return to IDLE. The frame is valid if stop=1 and the 9 bits (data + parity) have odd parity; a valid frame pushes the byte. Otherwise set the sticky ERR flag and push nothing.
- Timeout: a counter reloads on every strobe. If it reaches TIMEOUT in any state other than IDLE, the FSM returns to IDLE, ERR is set, and nothing is pushed.
- Register map:
  - 0 DATA. Read returns {valid, 7'b0, byte} in bits [15:0], upper bits 0. A read with sel=1, we=0 and a non-empty FIFO pops the FIFO at the clock edge. Reading while empty returns 0 and does not pop.
  - 1 STATUS. Read returns bit0 empty, bit1 full, bit2 ERR, bit3 OVF, bits[15:8] count.
  - 2 CTRL. Write bit0=1 flushes the FIFO. Write bit1=1 clears ERR and OVF. Read returns 0.
  - 3 reserved. Read returns 0 and writes are ignored.
- FIFO full when a byte must be pushed: the byte is dropped and OVF is set. If a pop occurs in the same cycle, the push is accepted and count is unchanged.
- Pop and push in the same cycle on a non-empty FIFO: count is unchanged.
- Flush and push in the same cycle: flush wins, the FIFO ends empty, and the byte is lost without setting OVF.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is a separate log2(FIFO_DEPTH)+1-bit counter.

## Timing
- Reset values: FSM IDLE, FIFO empty (count 0), ERR=0, OVF=0, filtered clock 1, synchronizers 1, timeout counter 0.
- data_out has zero latency, matching single-cycle load instructions. A pop's effect is visible from the next cycle.
- Latency from a ps2_clk pin fall to the strobe is 2 sync cycles plus FILT_LEN cycles.
- A pushed byte is readable from the cycle after the stop-bit strobe.
- Reset during a frame discards the partial frame. The next frame is received only if reset releases before its start bit.

## Structure
- Shared defines (xdefs.vh style include): register offsets, STATUS bit positions, FSM state encodings.
- One natural sub-module, `xfifo_sync`: a parameterized synchronous FIFO with push, pop, flush, empty, full and count outputs.

## Test plan
- Frame 0x1C with correct parity (0) and stop 1 → DATA read returns 0x801C, STATUS then reads empty=1 with count 0.
- Frame 0x5A with parity forced wrong → no push, ERR=1; a CTRL write of 0x2 clears ERR.
- Start bit plus 4 data bits, then silence beyond TIMEOUT → FSM returns to IDLE and ERR=1. A following frame 0xF0 is received correctly.
- Push FIFO_DEPTH+1 frames (0x01..0x09) without reading → full=1, OVF=1, reads return 0x01..0x08 in order, and 0x09 is lost.
- A pop on the same cycle as the stop strobe with the FIFO full → count stays FIFO_DEPTH and the new byte is accepted.
- Glitch on ps2_clk shorter than FILT_LEN cycles → no strobe and no bit shifted. Reset asserted mid-frame → FIFO empty and the FSM in IDLE.
